axis_circular_acq_ctrl: RTL

Sequencer for the circular pre/post-trigger packetizer and the RAM writer that follows it. Each acquisition runs in this order:
- hold the packetizer in reset;
- release it and count pre-trigger beats;
- accept a hardware or software trigger;
- assert the packetizer's level trigger until its complete flag rises;
- wait a drain interval for the writer;
- latch the buffer start position and phase for software, then optionally re-arm.

---
 rtl/axis_circular_acq_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/axis_circular_acq_ctrl.sv
// Acquisition sequencer for a circular pre/post-trigger packetizer and its RAM writer:
// reset -> pre-fill -> armed -> post-trigger -> drain -> done, with abort and optional auto re-arm.
module axis_circular_acq_ctrl #(
  parameter int CNTR_WIDTH   = 32,
  parameter int BUF_WIDTH    = 16,
  parameter int PHASE_WIDTH  = 32,
  parameter int RST_CYCLES   = 4,
  parameter int DRAIN_CYCLES = 16
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   cfg_arm,
  input  logic                   cfg_abort,
  input  logic                   cfg_auto,
  input  logic                   cfg_ack,
  input  logic [CNTR_WIDTH-1:0]  cfg_pre,
  input  logic [CNTR_WIDTH-1:0]  cfg_post,
  input  logic                   cfg_trig_en,
  input  logic                   ext_trigger,
  input  logic                   sw_trigger,
  input  logic                   beat,
  input  logic [CNTR_WIDTH-1:0]  pkt_trigger_pos,
  input  logic                   pkt_complete,
  input  logic [PHASE_WIDTH-1:0] pkt_phase,
  output logic                   pkt_aresetn,
  output logic [CNTR_WIDTH-1:0]  pkt_cfg_data,
  output logic                   pkt_trigger,
  output logic [BUF_WIDTH-1:0]   start_pos,
  output logic [PHASE_WIDTH-1:0] trig_phase,
  output logic [31:0]            acq_count,
  output logic [2:0]             state,
  output logic                   busy,
  output logic                   done_irq,
  output logic                   cfg_error
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RST   = 3'd1;
  localparam logic [2:0] S_PRE   = 3'd2;
  localparam logic [2:0] S_ARMED = 3'd3;
  localparam logic [2:0] S_POST  = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam logic [CNTR_WIDTH:0]   BUF_DEPTH  = (CNTR_WIDTH+1)'(1) << BUF_WIDTH;
  localparam logic [CNTR_WIDTH-1:0] RST_LAST   = CNTR_WIDTH'(RST_CYCLES - 1);
  localparam logic [CNTR_WIDTH-1:0] DRAIN_LAST = CNTR_WIDTH'(DRAIN_CYCLES - 1);

  logic [2:0]            state_reg, state_next;
  logic [CNTR_WIDTH-1:0] cnt_reg;
  logic                  arm_prev_reg, ext_prev_reg;
  logic [CNTR_WIDTH:0]   cfg_sum;
  logic                  cfg_bad, arm_rise, ext_rise, trig_hit;
  logic                  rst_done, pre_done, drain_done, done_entry, capture;
  logic                  unused_pos_bits;

  // Sum is one bit wider than the counters so a huge pre+post cannot wrap into range.
  assign cfg_sum    = {1'b0, cfg_pre} + {1'b0, cfg_post};
  assign cfg_bad    = (cfg_sum > BUF_DEPTH) || (cfg_post == '0);
  assign arm_rise   = cfg_arm & ~arm_prev_reg;
  assign ext_rise   = ext_trigger & ~ext_prev_reg;
  assign trig_hit   = sw_trigger | (cfg_trig_en & ext_rise);
  assign rst_done   = (cnt_reg == RST_LAST);
  assign pre_done   = (cnt_reg == cfg_pre);
  assign drain_done = (cnt_reg == DRAIN_LAST);
  assign done_entry = (state_reg == S_DRAIN) && drain_done && !cfg_abort;
  assign capture    = (state_reg == S_POST) && pkt_complete && !cfg_abort;

  assign pkt_cfg_data    = cfg_post;
  assign state           = state_reg;
  assign busy            = (state_reg != S_IDLE);
  assign unused_pos_bits = ^pkt_trigger_pos[CNTR_WIDTH-1:BUF_WIDTH];

  always_ff @(posedge aclk) begin
    if (!aresetn) state_reg <= S_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (cfg_abort) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE:  if (arm_rise && !cfg_bad) state_next = S_RST;
        S_RST:   if (rst_done)             state_next = S_PRE;
        S_PRE:   if (pre_done)             state_next = S_ARMED;
        S_ARMED: if (trig_hit)             state_next = S_POST;
        S_POST:  if (pkt_complete)         state_next = S_DRAIN;
        S_DRAIN: if (drain_done)           state_next = S_DONE;
        S_DONE: begin
          if (cfg_auto)     state_next = S_RST;
          else if (cfg_ack) state_next = S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    pkt_aresetn = 1'b0;
    pkt_trigger = 1'b0;
    case (state_reg)
      S_PRE, S_ARMED, S_DONE: pkt_aresetn = 1'b1;
      S_POST, S_DRAIN: begin
        pkt_aresetn = 1'b1;
        pkt_trigger = 1'b1;
      end
      default: ;
    endcase
  end

  // One counter serves RST/DRAIN (cycles) and PRE (beats); it restarts on every state change.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cnt_reg <= '0;
    end else if (state_next != state_reg) begin
      cnt_reg <= '0;
    end else if (state_reg == S_PRE) begin
      cnt_reg <= cnt_reg + CNTR_WIDTH'(beat);
    end else if (state_reg == S_RST || state_reg == S_DRAIN) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      arm_prev_reg <= 1'b0;
      ext_prev_reg <= 1'b0;
      start_pos    <= '0;
      trig_phase   <= '0;
      acq_count    <= '0;
      done_irq     <= 1'b0;
      cfg_error    <= 1'b0;
    end else begin
      arm_prev_reg <= cfg_arm;
      ext_prev_reg <= ext_trigger;
      done_irq     <= done_entry;
      if (done_entry) acq_count <= acq_count + 32'd1;
      if (capture) begin
        start_pos  <= pkt_trigger_pos[BUF_WIDTH-1:0] - cfg_pre[BUF_WIDTH-1:0];
        trig_phase <= pkt_phase;
      end
      if (state_reg == S_IDLE && arm_rise && !cfg_abort) cfg_error <= cfg_bad;
    end
  end

endmodule
